mdu_sequencer: RTL and testbench

Sequencing controller for the multiply/divide unit used by the execution stage. It owns the HI/LO registers and runs multi-cycle MULT/DIV operations: fixed-latency multiply and a radix-2 restoring divider, one quotient bit per cycle. It drives `busy` so the execution stage stalls, and answers HI/LO reads and writes.

---
 rtl/mdu_sequencer_pkg.sv | 41 ++++
 rtl/mdu_divider_core.sv | 82 ++++++++
 rtl/mdu_sequencer.sv | 162 ++++++++++++++++
 tb/tb_mdu_sequencer.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/mdu_sequencer_pkg.sv
// Shared types and constants for the multiply/divide sequencer and its divider core.
package mdu_sequencer_pkg;

  typedef enum logic [3:0] {
    MDU_NONE    = 4'd0,
    MDU_READ_HI = 4'd1,
    MDU_READ_LO = 4'd2,
    MDU_MTHI    = 4'd3,
    MDU_MTLO    = 4'd4,
    MDU_MULT    = 4'd5,
    MDU_MULTU   = 4'd6,
    MDU_DIV     = 4'd7,
    MDU_DIVU    = 4'd8,
    MDU_MADD    = 4'd9,
    MDU_MADDU   = 4'd10,
    MDU_MSUB    = 4'd11,
    MDU_MSUBU   = 4'd12
  } mdu_operation_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MUL     = 2'd1,
    ST_DIV     = 2'd2,
    ST_DIV_FIX = 2'd3
  } mdu_state_t;

  localparam int          MDU_DIV_CYCLES    = 33;
  localparam logic [31:0] MDU_DIV0_QUOTIENT = 32'hFFFF_FFFF;

  // Full 64-bit product; operands are extended to 64 bits before multiplying.
  function automatic logic [63:0] mdu_product(input logic [31:0] a,
                                              input logic [31:0] b,
                                              input logic        is_signed);
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    a_ext = is_signed ? {{32{a[31]}}, a} : {32'd0, a};
    b_ext = is_signed ? {{32{b[31]}}, b} : {32'd0, b};
    return a_ext * b_ext;
  endfunction

endpackage

// File: rtl/mdu_divider_core.sv
// Radix-2 restoring divider datapath: load latches magnitudes and signs, each step
// produces one quotient bit, and the outputs carry the sign-corrected results.
module mdu_divider_core
  import mdu_sequencer_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            load,
  input  logic            step,
  input  logic            is_signed,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dsr_q, dsr_d;
  logic            q_neg_q, q_neg_d;
  logic            r_neg_q, r_neg_d;
  logic            zero_q, zero_d;

  logic            a_neg, b_neg;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;

  always_comb begin
    rem_d   = rem_q;
    quo_d   = quo_q;
    dsr_d   = dsr_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    zero_d  = zero_q;
    a_neg   = is_signed & dividend[XLEN-1];
    b_neg   = is_signed & divisor[XLEN-1];
    shifted = {rem_q, quo_q[XLEN-1]};
    diff    = shifted - {1'b0, dsr_q};
    if (load) begin
      quo_d   = a_neg ? -dividend : dividend;
      dsr_d   = b_neg ? -divisor : divisor;
      rem_d   = '0;
      q_neg_d = a_neg ^ b_neg;
      r_neg_d = a_neg;
      zero_d  = (divisor == '0);
    end else if (step) begin
      // A clear borrow bit means the trial subtraction fits.
      if (!diff[XLEN]) begin
        rem_d = diff[XLEN-1:0];
        quo_d = {quo_q[XLEN-2:0], 1'b1};
      end else begin
        rem_d = shifted[XLEN-1:0];
        quo_d = {quo_q[XLEN-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rem_q   <= '0;
      quo_q   <= '0;
      dsr_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dsr_q   <= dsr_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      zero_q  <= zero_d;
    end
  end

  // Divide-by-zero forces the all-ones quotient; the remainder naturally equals the dividend.
  assign quotient  = zero_q ? MDU_DIV0_QUOTIENT : (q_neg_q ? -quo_q : quo_q);
  assign remainder = r_neg_q ? -rem_q : rem_q;

endmodule

// File: rtl/mdu_sequencer.sv
// Multiply/divide sequencer owning HI/LO; fixed-latency multiply, 33-cycle divide.
// Optional MADD/MSUB accumulate ops are built only when MDU_MADD_EN is defined.
module mdu_sequencer
  import mdu_sequencer_pkg::*;
#(
  parameter int MUL_LATENCY = 5,
  parameter int XLEN        = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  mdu_operation_t  operation,
  input  logic [XLEN-1:0] operand1,
  input  logic [XLEN-1:0] operand2,
  output logic            busy,
  output logic [XLEN-1:0] dataRead,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  mdu_state_t        state_q, state_d;
  logic              busy_q, busy_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic [2*XLEN-1:0] prod_q, prod_d;
`ifdef MDU_MADD_EN
  logic              acc_en_q, acc_en_d;
  logic              acc_sub_q, acc_sub_d;
`endif

  logic              div_load;
  logic              div_step;
  logic              div_signed;
  logic [XLEN-1:0]   div_quo;
  logic [XLEN-1:0]   div_rem;

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    prod_d     = prod_q;
    div_load   = 1'b0;
    div_step   = 1'b0;
    div_signed = (operation == MDU_DIV);
`ifdef MDU_MADD_EN
    acc_en_d   = acc_en_q;
    acc_sub_d  = acc_sub_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (operation)
            MDU_MTHI: hi_d = operand1;
            MDU_MTLO: lo_d = operand1;
            MDU_MULT, MDU_MULTU: begin
              prod_d  = mdu_product(operand1, operand2, operation == MDU_MULT);
              state_d = ST_MUL;
              busy_d  = 1'b1;
              cnt_d   = 5'(MUL_LATENCY - 1);
`ifdef MDU_MADD_EN
              acc_en_d = 1'b0;
`endif
            end
`ifdef MDU_MADD_EN
            MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU: begin
              prod_d    = mdu_product(operand1, operand2,
                                      operation == MDU_MADD || operation == MDU_MSUB);
              state_d   = ST_MUL;
              busy_d    = 1'b1;
              cnt_d     = 5'(MUL_LATENCY - 1);
              acc_en_d  = 1'b1;
              acc_sub_d = (operation == MDU_MSUB || operation == MDU_MSUBU);
            end
`endif
            MDU_DIV, MDU_DIVU: begin
              div_load = 1'b1;
              state_d  = ST_DIV;
              busy_d   = 1'b1;
              cnt_d    = 5'(MDU_DIV_CYCLES - 2);
            end
            default: ;
          endcase
        end
      end
      ST_MUL: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
`ifdef MDU_MADD_EN
          if (acc_en_q)
            {hi_d, lo_d} = acc_sub_q ? ({hi_q, lo_q} - prod_q) : ({hi_q, lo_q} + prod_q);
          else
            {hi_d, lo_d} = prod_q;
`else
          {hi_d, lo_d} = prod_q;
`endif
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      ST_DIV: begin
        div_step = 1'b1;
        if (cnt_q == '0) state_d = ST_DIV_FIX;
        else             cnt_d   = cnt_q - 5'd1;
      end
      ST_DIV_FIX: begin
        lo_d    = div_quo;
        hi_d    = div_rem;
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      prod_q    <= '0;
`ifdef MDU_MADD_EN
      acc_en_q  <= 1'b0;
      acc_sub_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      prod_q    <= prod_d;
`ifdef MDU_MADD_EN
      acc_en_q  <= acc_en_d;
      acc_sub_q <= acc_sub_d;
`endif
    end
  end

  mdu_divider_core #(.XLEN(XLEN)) u_div (
    .clock     (clock),
    .reset     (reset),
    .load      (div_load),
    .step      (div_step),
    .is_signed (div_signed),
    .dividend  (operand1),
    .divisor   (operand2),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  assign busy     = busy_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign dataRead = (operation == MDU_READ_HI) ? hi_q : lo_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed self-checking bench for mdu_sequencer with hand-computed HI/LO results.
module tb_mdu_sequencer;
  import mdu_sequencer_pkg::*;

  logic           clock = 1'b0;
  logic           reset;
  logic           start;
  mdu_operation_t operation;
  logic [31:0]    operand1;
  logic [31:0]    operand2;
  logic           busy;
  logic [31:0]    dataRead;
  logic [31:0]    hi;
  logic [31:0]    lo;

  int n_checks = 0;
  int n_fail   = 0;
  int cycles;

  mdu_sequencer #(.MUL_LATENCY(5), .XLEN(32)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .operation (operation),
    .operand1  (operand1),
    .operand2  (operand2),
    .busy      (busy),
    .dataRead  (dataRead),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic start_op(input mdu_operation_t op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    start     = 1'b1;
    operation = op;
    operand1  = a;
    operand2  = b;
    @(posedge clock);
    #1;
    start     = 1'b0;
    operation = MDU_NONE;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(posedge clock);
      #1;
    end
  endtask

  task automatic run_op(input string tag, input mdu_operation_t op,
                        input logic [31:0] a, input logic [31:0] b,
                        input int exp_cycles, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    start_op(op, a, b);
    wait_idle(n);
    chk({tag, "_cycles"}, 64'(n), 64'(exp_cycles));
    chk({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    chk({tag, "_lo"}, 64'(lo), 64'(exp_lo));
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    operation = MDU_NONE;
    operand1  = '0;
    operand2  = '0;
    #12;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_read", 64'(dataRead), 64'd0);
    @(negedge clock);
    reset = 1'b0;

    run_op("mult",   MDU_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 5,  32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu",  MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5,  32'hFFFF_FFFE, 32'h0000_0001);
    run_op("div",    MDU_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu",   MDU_DIVU,  32'd100,       32'd7,         33, 32'd2,         32'd14);
    chk("read_lo", 64'(dataRead), 64'd14);
    run_op("divu0",  MDU_DIVU,  32'h0000_0064, 32'h0,         33, 32'h0000_0064, 32'hFFFF_FFFF);
    run_op("div0s",  MDU_DIV,   32'hFFFF_FFF0, 32'h0,         33, 32'hFFFF_FFF0, 32'hFFFF_FFFF);
    run_op("divovf", MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0,         32'h8000_0000);

    // MTHI followed by a read on the next cycle
    start_op(MDU_MTHI, 32'h1234_5678, 32'h0);
    chk("mthi_busy", 64'(busy), 64'd0);
    @(negedge clock);
    operation = MDU_READ_HI;
    #1;
    chk("read_hi", 64'(dataRead), 64'h1234_5678);
    chk("read_hi_busy", 64'(busy), 64'd0);
    start_op(MDU_MTLO, 32'hCAFE_0001, 32'h0);
    chk("mtlo", 64'(lo), 64'hCAFE_0001);

    // MULT issued on the third busy cycle of a DIV must be dropped
    start_op(MDU_DIVU, 32'd100, 32'd7);
    @(posedge clock);
    #1;
    start_op(MDU_MULT, 32'd2, 32'd3);
    wait_idle(cycles);
    chk("ign_cycles", 64'(cycles + 2), 64'd33);
    chk("ign_hi", 64'(hi), 64'd2);
    chk("ign_lo", 64'(lo), 64'd14);

    // Reset mid-divide clears state asynchronously
    start_op(MDU_DIV, 32'hFFFF_FFF9, 32'h2);
    repeat (9) begin
      @(posedge clock);
      #1;
    end
    #2;
    reset = 1'b1;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_hi", 64'(hi), 64'd0);
    chk("arst_lo", 64'(lo), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    run_op("mult_post", MDU_MULT, 32'd2, 32'd3, 5, 32'd0, 32'd6);

`ifdef MDU_MADD_EN
    start_op(MDU_MTLO, 32'd10, 32'h0);
    start_op(MDU_MTHI, 32'd0, 32'h0);
    run_op("madd",  MDU_MADD,  32'd4, 32'd5,  5, 32'd0,         32'd30);
    run_op("msubu", MDU_MSUBU, 32'd1, 32'd31, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
`else
    // Accumulate encodings decode as no-ops in the default build
    start_op(MDU_MADD, 32'd4, 32'd5);
    chk("madd_off_busy", 64'(busy), 64'd0);
    chk("madd_off_lo", 64'(lo), 64'd6);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
